// File: rtl/gtp_init_pkg.sv
// Shared definitions for the GTP TX init sequencer: state encoding, default timing
// parameters and the per-state control output decode.
package gtp_init_pkg;

    localparam int POWERUP_CYCLES_DEF   = 8;
    localparam int PLL_RESET_CYCLES_DEF = 4;
    localparam int LOCK_TIMEOUT_DEF     = 64;
    localparam int DONE_TIMEOUT_DEF     = 64;
    localparam int MAX_RETRIES_DEF      = 3;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_TX_RST,
        ST_WAIT_DONE,
        ST_READY,
        ST_FAULT
    } state_e;

    typedef struct packed {
        logic pll0reset;
        logic gttxreset;
        logic txuserrdy;
        logic ready;
        logic fault;
    } ctl_t;

    localparam ctl_t CTL_RESET = 5'b11000;

    // Control outputs are a pure function of the state being entered.
    function automatic ctl_t state_ctl(state_e s);
        case (s)
            ST_POWERUP:   return 5'b01000;
            ST_PLL_RST:   return 5'b11000;
            ST_WAIT_LOCK: return 5'b01000;
            ST_TX_RST:    return 5'b01000;
            ST_WAIT_DONE: return 5'b00100;
            ST_READY:     return 5'b00110;
            default:      return 5'b11001;
        endcase
    endfunction

endpackage

// File: rtl/gtp_tx_init_if.sv
// Signal bundle between the TX init sequencer (master) and the GTP common/channel (slave).
interface gtp_tx_init_if;

    logic       pll0lock;
    logic       pll0refclklost;
    logic       txresetdone;
    logic       pll0reset;
    logic       gttxreset;
    logic       txuserrdy;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;

    modport master (
        input  pll0lock, pll0refclklost, txresetdone,
        output pll0reset, gttxreset, txuserrdy, ready, fault, retry_cnt
    );

    modport slave (
        output pll0lock, pll0refclklost, txresetdone,
        input  pll0reset, gttxreset, txuserrdy, ready, fault, retry_cnt
    );

endinterface

// File: rtl/gtp_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; flops clear on reset.
module gtp_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gtp_tx_init.sv
// GTP TX bring-up sequencer: PLL0 reset, lock wait, TX reset, done wait, with retry and fault.
//   state      | meaning
//   POWERUP    | settle after reset release
//   PLL_RST    | pulse pll0reset
//   WAIT_LOCK  | wait for PLL0 lock, bounded
//   TX_RST     | one-cycle TX reset step
//   WAIT_DONE  | txuserrdy up, wait for txresetdone, bounded
//   READY      | link TX initialised, watch lock/refclk
//   FAULT      | retries exhausted, held until rst
module gtp_tx_init
    import gtp_init_pkg::*;
#(
    parameter int POWERUP_CYCLES   = POWERUP_CYCLES_DEF,
    parameter int PLL_RESET_CYCLES = PLL_RESET_CYCLES_DEF,
    parameter int LOCK_TIMEOUT     = LOCK_TIMEOUT_DEF,
    parameter int DONE_TIMEOUT     = DONE_TIMEOUT_DEF,
    parameter int MAX_RETRIES      = MAX_RETRIES_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    gtp_tx_init_if.master io_gtp
);

    localparam int MAX_AB  = (POWERUP_CYCLES > PLL_RESET_CYCLES) ? POWERUP_CYCLES : PLL_RESET_CYCLES;
    localparam int MAX_CD  = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic w_lock_s;
    logic w_lost_s;
    logic w_done_s;
    logic w_bad;
    logic w_retry;
    state_e w_next;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    ctl_t             r_ctl;

    gtp_sync_2ff u_sync_lock (.i_clk(i_clk), .i_rst(i_rst), .i_d(io_gtp.pll0lock),       .o_q(w_lock_s));
    gtp_sync_2ff u_sync_lost (.i_clk(i_clk), .i_rst(i_rst), .i_d(io_gtp.pll0refclklost), .o_q(w_lost_s));
    gtp_sync_2ff u_sync_done (.i_clk(i_clk), .i_rst(i_rst), .i_d(io_gtp.txresetdone),    .o_q(w_done_s));

    assign w_bad = w_lost_s | ~w_lock_s;

    always_comb begin
        w_next  = r_state;
        w_retry = 1'b0;
        case (r_state)
            ST_POWERUP:   if (r_cnt == PWR_LAST) w_next = ST_PLL_RST;
            ST_PLL_RST:   if (r_cnt == PLL_LAST) w_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (!w_bad)                  w_next  = ST_TX_RST;
                else if (r_cnt == LOCK_LAST) w_retry = 1'b1;
            end
            ST_TX_RST: begin
                if (w_bad) w_retry = 1'b1;
                else       w_next  = ST_WAIT_DONE;
            end
            // link loss outranks a simultaneous done
            ST_WAIT_DONE: begin
                if (w_bad)                   w_retry = 1'b1;
                else if (w_done_s)           w_next  = ST_READY;
                else if (r_cnt == DONE_LAST) w_retry = 1'b1;
            end
            ST_READY:     if (w_bad) w_retry = 1'b1;
            ST_FAULT:     w_next = ST_FAULT;
            default:      w_next = ST_POWERUP;
        endcase
        if (w_retry)
            w_next = (r_retry == 4'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_POWERUP;
            r_cnt   <= '0;
            r_retry <= '0;
            r_ctl   <= CTL_RESET;
        end else begin
            r_state <= w_next;
            r_ctl   <= state_ctl(w_next);
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != CNT_SAT)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_retry && r_retry != 4'hf)
                r_retry <= r_retry + 4'd1;
        end
    end

    assign io_gtp.pll0reset = r_ctl.pll0reset;
    assign io_gtp.gttxreset = r_ctl.gttxreset;
    assign io_gtp.txuserrdy = r_ctl.txuserrdy;
    assign io_gtp.ready     = r_ctl.ready;
    assign io_gtp.fault     = r_ctl.fault;
    assign io_gtp.retry_cnt = r_retry;

endmodule

// File: tb/tb_gtp_tx_init.sv
// Bench for gtp_tx_init: a phase-level timeline model predicts every output change; a monitor checks them.
module tb_gtp_tx_init;

    localparam int MAXC = 1024;
    localparam int MAXR = 3;
    localparam logic [4:0] C_RST = 5'b11000;
    localparam logic [4:0] C_PWR = 5'b01000;
    localparam logic [4:0] C_PLL = 5'b11000;
    localparam logic [4:0] C_WL  = 5'b01000;
    localparam logic [4:0] C_TX  = 5'b01000;
    localparam logic [4:0] C_WD  = 5'b00100;
    localparam logic [4:0] C_RDY = 5'b00110;
    localparam logic [4:0] C_FLT = 5'b11001;
    localparam logic [8:0] RST_VEC = 9'b110000000;
    localparam int P_PLL = 0, P_WL = 1, P_TX = 2, P_WD = 3, P_RDY = 4, P_RETRY = 5;

    typedef struct {
        int         edge_n;
        logic [8:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   cyc0 = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    logic [8:0] mon_prev;
    logic [8:0] m_prev;
    ev_t  exp_q[$];

    bit lock_in[MAXC];
    bit lost_in[MAXC];
    bit done_in[MAXC];
    int s_done_delay, s_lost_gap;
    bit s_drop, lost_used, drop_used;

    gtp_tx_init_if bus();

    gtp_tx_init dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_gtp (bus.master)
    );

    wire [8:0] dut_v = {bus.pll0reset, bus.gttxreset, bus.txuserrdy, bus.ready, bus.fault, bus.retry_cnt};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic void emit(int e, logic [4:0] c, int rc);
        logic [8:0] v;
        v = {c, rc[3:0]};
        if (v != m_prev) begin
            exp_q.push_back('{e, v});
            m_prev = v;
        end
    endfunction

    // Value the controller acts on at edge e: input driven after edge e-3, zero until
    // the synchronizer has refilled since the reset at edge base.
    function automatic bit syn(int which, int e, int base);
        int j;
        j = e - 3;
        if (j < base || j >= MAXC) return 1'b0;
        if (which == 0) return lock_in[j];
        if (which == 1) return lost_in[j];
        return done_in[j];
    endfunction

    function automatic bit link_ok(int e, int base);
        return syn(0, e, base) && !syn(1, e, base);
    endfunction

    function automatic void model_run(int base, int stop);
        int ent, rc, ph, hit;
        rc = 0;
        if (base + 1 > stop) return;
        emit(base + 1, C_PWR, 0);
        ent = base + 8;
        ph  = P_PLL;
        while (ent <= stop) begin
            case (ph)
                P_PLL: begin
                    emit(ent, C_PLL, rc);
                    ent += 4;
                    ph = P_WL;
                end
                P_WL: begin
                    emit(ent, C_WL, rc);
                    hit = 0;
                    for (int k = 1; k <= 64 && hit == 0; k++)
                        if (link_ok(ent + k, base)) hit = k;
                    ph  = (hit != 0) ? P_TX : P_RETRY;
                    ent += (hit != 0) ? hit : 64;
                end
                P_TX: begin
                    emit(ent, C_TX, rc);
                    ent += 1;
                    ph = link_ok(ent, base) ? P_WD : P_RETRY;
                end
                P_WD: begin
                    emit(ent, C_WD, rc);
                    if (s_done_delay >= 0) begin
                        for (int j = ent; j < MAXC; j++) done_in[j] = (j >= ent + s_done_delay);
                        if (s_drop && !drop_used) begin
                            drop_used = 1'b1;
                            for (int j = ent + s_done_delay; j < ent + s_done_delay + 20 && j < MAXC; j++)
                                lock_in[j] = 1'b0;
                        end
                    end
                    hit = 0;
                    ph  = P_RETRY;
                    for (int k = 1; k <= 64 && hit == 0; k++) begin
                        if (!link_ok(ent + k, base)) hit = k;
                        else if (syn(2, ent + k, base)) begin
                            hit = k;
                            ph  = P_RDY;
                        end
                    end
                    ent += (hit != 0) ? hit : 64;
                end
                P_RDY: begin
                    emit(ent, C_RDY, rc);
                    if (s_lost_gap >= 0 && !lost_used) begin
                        lost_used = 1'b1;
                        for (int j = ent + s_lost_gap; j < ent + s_lost_gap + 3 && j < MAXC; j++)
                            lost_in[j] = 1'b1;
                    end
                    hit = 0;
                    for (int e = ent + 1; e <= stop && hit == 0; e++)
                        if (!link_ok(e, base)) hit = e - ent;
                    if (hit != 0) begin
                        ent += hit;
                        ph = P_RETRY;
                    end else begin
                        ent = stop + 1;
                    end
                end
                default: begin
                    for (int j = ent; j < MAXC; j++) done_in[j] = 1'b0;
                    if (rc == MAXR) begin
                        rc++;
                        emit(ent, C_FLT, rc);
                        ent = stop + 1;
                    end else begin
                        rc++;
                        ph = P_PLL;
                    end
                end
            endcase
        end
    endfunction

    function automatic void build(int ls, int dd, int lg, bit dr, int ra, int len);
        for (int j = 0; j < MAXC; j++) begin
            lock_in[j] = (ls >= 0) && (j >= ls);
            lost_in[j] = 1'b0;
            done_in[j] = 1'b0;
        end
        s_done_delay = dd;
        s_lost_gap   = lg;
        s_drop       = dr;
        lost_used    = 1'b0;
        drop_used    = 1'b0;
        exp_q.delete();
        m_prev = RST_VEC;
        if (ra > 0) begin
            model_run(0, ra - 1);
            emit(ra, C_RST, 0);
            model_run(ra, len);
        end else begin
            model_run(0, len);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on && dut_v !== mon_prev) begin
            ev_t ev;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change edge=%0d got=%b required=no change", cyc - cyc0, dut_v);
            end else begin
                ev = exp_q.pop_front();
                if (ev.edge_n != cyc - cyc0 || ev.v !== dut_v) begin
                    errors++;
                    $display("FAIL out_change got edge=%0d value=%b required edge=%0d value=%b",
                             cyc - cyc0, dut_v, ev.edge_n, ev.v);
                end
            end
            mon_prev = dut_v;
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(int e);
        bus.pll0lock       = (e < MAXC) ? lock_in[e] : 1'b0;
        bus.pll0refclklost = (e < MAXC) ? lost_in[e] : 1'b0;
        bus.txresetdone    = (e < MAXC) ? done_in[e] : 1'b0;
    endtask

    task automatic scenario(string name, int ls, int dd, int lg, bit dr, int ra, int len);
        build(ls, dd, lg, dr, ra, len);
        rst = 1'b1;
        bus.pll0lock = 1'b0;
        bus.pll0refclklost = 1'b0;
        bus.txresetdone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cyc0 = cyc;
        rst  = 1'b0;
        apply(0);
        checks++;
        if (dut_v !== RST_VEC) begin
            errors++;
            $display("FAIL reset_vec %s got=%b required=%b", name, dut_v, RST_VEC);
        end
        mon_prev = RST_VEC;
        mon_on   = 1'b1;
        for (int e = 1; e <= len; e++) begin
            @(posedge clk);
            #1;
            rst = (e == ra - 1);
            apply(e);
        end
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes %s got=%0d pending required=0 (next edge=%0d value=%b)",
                     name, exp_q.size(), exp_q[0].edge_n, exp_q[0].v);
        end
    endtask

    initial begin
        int ls, dd, lg, ra, r;
        bit dr;
        bus.pll0lock = 1'b0;
        bus.pll0refclklost = 1'b0;
        bus.txresetdone = 1'b0;
        mon_prev = RST_VEC;
        m_prev   = RST_VEC;

        scenario("bringup",      20,  2, -1, 1'b0, -1, 200);
        scenario("lock_timeout", -1, -1, -1, 1'b0, -1, 400);
        scenario("refclk_lost",  20,  2, 10, 1'b0, -1, 300);
        scenario("done_timeout", 20, -1, -1, 1'b0, -1, 200);
        scenario("rst_in_wdone", 20, -1, -1, 1'b0, 54, 150);
        scenario("lost_vs_done", 20,  2, -1, 1'b1, -1, 300);

        for (int n = 0; n < 8; n++) begin
            ls = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 100));
            r  = int'($urandom_range(0, 5));
            dd = (r == 0) ? -1 : (r == 1) ? 70 : int'($urandom_range(0, 10));
            lg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
            dr = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 300)) : -1;
            scenario("random", ls, dd, lg, dr, ra, 500);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gtp_tx_init.md
GTP_TX_INIT -- requirements
Module: gtp_tx_init

Interface
REQ-001 Parameter POWERUP_CYCLES, default 8: wait after reset release before the first PLL reset.
REQ-002 Parameter PLL_RESET_CYCLES, default 4: pll0reset pulse width.
REQ-003 Parameter LOCK_TIMEOUT, default 64: maximum cycles in WAIT_LOCK.
REQ-004 Parameter DONE_TIMEOUT, default 64: maximum cycles in WAIT_DONE.
REQ-005 Parameter MAX_RETRIES, default 3: restart attempts before FAULT.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 pll0lock  in  1  PLL0 lock from the GTPE2_COMMON; asynchronous.
REQ-009 pll0refclklost  in  1  reference clock lost from the common block; asynchronous.
REQ-010 txresetdone  in  1  channel TX reset done; asynchronous.
REQ-011 pll0reset  out  1  PLL0 reset to the common block.
REQ-012 gttxreset  out  1  channel TX reset.
REQ-013 txuserrdy  out  1  TX user clock ready to the channel.
REQ-014 ready  out  1  link TX initialised.
REQ-015 fault  out  1  retries exhausted; sticky until rst.
REQ-016 retry_cnt  out  4  restarts performed since rst, saturating at 15.

Function
REQ-017 pll0lock, pll0refclklost and txresetdone SHALL each pass through a two-flop synchronizer (2-cycle latency); the FSM uses only the synchronized copies (lock_s, lost_s, done_s).
REQ-018 States SHALL be POWERUP, PLL_RST, WAIT_LOCK, TX_RST, WAIT_DONE, READY, FAULT.
REQ-019 POWERUP: count POWERUP_CYCLES, then go to PLL_RST.
REQ-020 PLL_RST: pll0reset=1 and gttxreset=1 for exactly PLL_RESET_CYCLES, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK: gttxreset=1; lock_s=1 and lost_s=0 goes to TX_RST; LOCK_TIMEOUT cycles without lock counts as a retry event.
REQ-022 TX_RST: gttxreset=1 for exactly 1 cycle, then go to WAIT_DONE.
REQ-023 WAIT_DONE: txuserrdy=1; done_s=1 goes to READY; DONE_TIMEOUT cycles without done counts as a retry event.
REQ-024 READY: txuserrdy=1 and ready=1; lock_s=0 or lost_s=1 counts as a retry event.
REQ-025 lock_s=0 or lost_s=1 while in TX_RST or WAIT_DONE SHALL count as a retry event; lost priority over done when both occur in the same cycle.
REQ-026 Retry event: increment retry_cnt (saturating); if retry_cnt before the increment equals MAX_RETRIES, go to FAULT, else go to PLL_RST.
REQ-027 FAULT: pll0reset=1, gttxreset=1, fault=1, ready=0; exit only on rst.
REQ-028 Outputs SHALL be registered and SHALL change in the same cycle the state register shows the new state; no combinational paths from input to output.
REQ-029 The per-state cycle counter SHALL clear on every state entry, be wide enough for the largest parameter, and never wrap.

Reset
REQ-030 While rst=1: state=POWERUP, pll0reset=1, gttxreset=1, txuserrdy=0, ready=0, fault=0, retry_cnt=0, synchronizer flops=0.
REQ-031 rst asserted in any state, including mid-pulse or in FAULT, SHALL take effect on the next edge and restart the full sequence.

Structure
REQ-032 A shared package gtp_init_pkg SHALL hold the state enum and the default parameter constants.
REQ-033 The synchronizer SHALL be a single sub-module, gtp_sync_2ff, instantiated three times.

Verification (default parameters)
REQ-034 Release rst, pll0lock=1 from cycle 20, txresetdone=1 two cycles after txuserrdy rises -> pll0reset high for 4 cycles after 8 POWERUP cycles; ready=1; retry_cnt=0.
REQ-035 pll0lock held at 0 -> three WAIT_LOCK timeouts of 64 cycles each, retry_cnt=3, then a fourth timeout -> fault=1, retry_cnt=4, pll0reset=1, and the block stays in FAULT.
REQ-036 In READY, pulse pll0refclklost for 3 cycles -> ready falls 3 cycles after the pulse starts, retry_cnt=1, PLL_RST re-entered, and ready=1 again after relock.
REQ-037 txresetdone never rises -> WAIT_DONE timeout after 64 cycles, gttxreset reasserted, retry_cnt increments.
REQ-038 Assert rst for 1 cycle in the middle of WAIT_DONE -> all outputs take their reset values next cycle and retry_cnt=0.
REQ-039 In WAIT_DONE, txresetdone rises in the same synchronized cycle that pll0lock falls -> retry taken; ready stays 0.
